uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for the `SERIAL_RX` pin of the top-level FPGA wrapper, the receive-side counterpart to the design's serial transmitter.
- Synchronises the line, detects start bits with mid-bit glitch rejection, and deserialises 8N1 frames, LSB first.
- Presents each byte through a one-entry valid/ready holding register.
- Reports framing errors and overruns as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 868: `CLK` cycles per bit (100 MHz / 115200). Must be ≥ 4. Counter width is `$clog2(CLKS_PER_BIT)`.
- `CLK` input 1: the only clock; all logic is on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `SERIAL_RX` input 1: asynchronous serial line, idle high.
- `RX_DATA` output 8: received byte; stable while `RX_VALID`=1.
- `RX_VALID` output 1: byte available; held until accepted.
- `RX_READY` input 1: consumer accepts the byte on any edge where `RX_VALID`=1 and `RX_READY`=1.
- `RX_FRAME_ERR` output 1: one-cycle pulse when the stop bit samples low.
- `RX_OVERRUN` output 1: one-cycle pulse when a byte completes while the holding register is full and not being accepted.
- `RX_PARITY_ERR` output 1: one-cycle pulse on a parity mismatch; tied 0 without `UART_RX_PARITY_EN`.

## Operation
- **Synchroniser:** two flops, both reset to 1. The FSM sees only the second flop, `rxs`.
- **Constant:** `HALF = CLKS_PER_BIT/2`, integer division.
- **IDLE:** `cnt`=0. If `rxs`=0, go to START.
- **START:** `cnt` increments each cycle. At `cnt`=`HALF-1`, sample `rxs`:
  - 1: false start; return to IDLE.
  - 0: go to DATA with `cnt`=0, `bitidx`=0.
- **DATA:** at `cnt`=`CLKS_PER_BIT-1`, shift `rxs` into bit 7 of the shift register (shift right), set `cnt`=0, increment `bitidx`. After bit 7, go to STOP (PARITY when the macro is defined).
- **STOP:** at `cnt`=`CLKS_PER_BIT-1`, sample `rxs`:
  - 1: frame good. Deliver the byte and go to IDLE immediately, half a bit early, for resync margin.
  - 0: pulse `RX_FRAME_ERR`, discard the byte, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rxs`=1, then go to IDLE. A held-low line (break) produces exactly one `RX_FRAME_ERR`.
- **Delivery**, on the edge where a good frame completes:
  - `RX_VALID`=0, or `RX_VALID`=1 with `RX_READY`=1: load `RX_DATA`, set `RX_VALID`=1.
  - `RX_VALID`=1 with `RX_READY`=0: keep the old byte, drop the new one, pulse `RX_OVERRUN`.
- **Acceptance with no completion:** `RX_VALID` and `RX_READY` both 1 → `RX_VALID`=0 on the next cycle.
- **Reset values:** `RX_DATA`=0x00, `RX_VALID`=0, all pulse outputs 0, FSM in IDLE, counters 0.
  - Reset mid-frame abandons the frame with no pulses.
  - If the line is still low after reset, the remaining low bits are treated as a start. That frame may error, which is acceptable.

## Timing
- **Edge numbering:** the line falls between edge 0 and edge 1. `rxs`=0 after edge 2, and START is entered at edge 3.
- **First data bit:** sampled at edge `3 + HALF + CLKS_PER_BIT`; each later data bit one `CLKS_PER_BIT` after the previous one.
- **Stop sample:** edge `3 + HALF + 9·CLKS_PER_BIT`.
- **Outputs:** `RX_VALID`, `RX_FRAME_ERR` and `RX_OVERRUN` are registered at the stop-sample edge and visible in the following cycle. Example: `CLKS_PER_BIT`=16 gives edge 155.
- **Back-to-back frames:** a start bit immediately after a stop bit is detected without loss, because the FSM is in IDLE from mid-stop.
- **Error pulses:** exactly 1 cycle wide.
- **Sustained throughput:** one byte per frame when `RX_READY` is held high.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`. When defined, an even-parity bit is expected between bit 7 and the stop bit (8E1).
  - PARITY state samples at `cnt`=`CLKS_PER_BIT-1`.
  - A mismatch pulses `RX_PARITY_ERR`, and the byte is discarded at STOP.
  - The framing check still applies. If both fail, both pulses assert in the same cycle.
  - All stop/valid timings shift by `+CLKS_PER_BIT`.
- **Undefined:** 8N1, no PARITY state, `RX_PARITY_ERR` constant 0.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **Single byte:** frame 0xA5, `RX_READY`=1 → `RX_DATA`=0xA5, `RX_VALID` high exactly 1 cycle, becoming visible after edge 155; no error pulses.
- **Glitch rejection:** 4-cycle low pulse on an idle line → no `RX_VALID`, no errors; FSM returns to IDLE. A following 0x3C frame is received correctly.
- **Framing error:** frame 0x55 with the stop bit low, then the line held low for 40 cycles → exactly one `RX_FRAME_ERR` pulse, no `RX_VALID`. A subsequent 0x81 frame is received after the line goes high.
- **Overrun and hold:** `RX_READY`=0, send 0x11 then 0x22 back-to-back →
  - `RX_DATA` stays 0x11 with `RX_VALID` held.
  - One `RX_OVERRUN` pulse at the second stop sample.
  - Raising `RX_READY` clears `RX_VALID` the next cycle.
- **Reset mid-frame:** assert `RST` for 1 cycle during bit 3 of 0xF0, line returned high →
  - All outputs at reset values, no pulses.
  - The next frame, 0x0F, is received correctly.
- **Parity (macro defined):** 0x07 with parity 1 → received. 0x07 with parity 0 → `RX_PARITY_ERR` pulse, no `RX_VALID`.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a two-flop line synchroniser, mid-bit start validation and a one-entry valid/ready holding register.
// Defining UART_RX_PARITY_EN switches to 8E1 and enables RX_PARITY_ERR.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SERIAL_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       RX_FRAME_ERR,
    output logic       RX_OVERRUN,
    output logic       RX_PARITY_ERR
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q;
    logic          rx_meta_q;
    logic          rxs_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bitidx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          ovr_q;
    logic          par_ok_d;

`ifdef UART_RX_PARITY_EN
    logic          par_bad_q;
    logic          perr_q;
    assign par_ok_d      = ~par_bad_q;
    assign RX_PARITY_ERR = perr_q;
`else
    assign par_ok_d      = 1'b1;
    assign RX_PARITY_ERR = 1'b0;
`endif

    assign RX_DATA      = data_q;
    assign RX_VALID     = valid_q;
    assign RX_FRAME_ERR = ferr_q;
    assign RX_OVERRUN   = ovr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bitidx_q  <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= SERIAL_RX;
            rxs_q     <= rx_meta_q;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            // A delivery later in this block overrides this clear.
            if (valid_q && RX_READY) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rxs_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q    <= '0;
                        bitidx_q <= '0;
                        state_q  <= rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q    <= '0;
                        shift_q  <= {rxs_q, shift_q[7:1]};
                        bitidx_q <= bitidx_q + 1'b1;
                        if (bitidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q     <= '0;
                        par_bad_q <= (^shift_q) ^ rxs_q;
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                        perr_q    <= par_bad_q;
                        par_bad_q <= 1'b0;
`endif
                        if (rxs_q) begin
                            // Leave mid-stop so a back-to-back start edge is not missed.
                            state_q <= S_IDLE;
                            if (par_ok_d) begin
                                if (valid_q && !RX_READY) begin
                                    ovr_q <= 1'b1;
                                end else begin
                                    data_q  <= shift_q;
                                    valid_q <= 1'b1;
                                end
                            end
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    cnt_q <= '0;
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: a table of single frames plus
// hand-written glitch, break, overrun, reset and (with UART_RX_PARITY_EN) parity sequences.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       CLK;
    logic       RST;
    logic       SERIAL_RX;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic       RX_FRAME_ERR;
    logic       RX_OVERRUN;
    logic       RX_PARITY_ERR;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .SERIAL_RX    (SERIAL_RX),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .RX_READY     (RX_READY),
        .RX_FRAME_ERR (RX_FRAME_ERR),
        .RX_OVERRUN   (RX_OVERRUN),
        .RX_PARITY_ERR(RX_PARITY_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    int edge_cnt = 0;
    int fall_edge = 0;
    int n_vrise, n_vhigh, n_ferr, n_ovr, n_perr;
    int vrise_edge, ovr_edge;
    logic [7:0] vrise_data;
    logic prev_valid = 1'b0;

    initial begin
        forever begin
            @(posedge CLK);
            edge_cnt++;
            #1;
            if (RX_VALID) n_vhigh++;
            if (RX_VALID && !prev_valid) begin
                n_vrise++;
                vrise_edge = edge_cnt;
                vrise_data = RX_DATA;
            end
            prev_valid = RX_VALID;
            if (RX_FRAME_ERR) n_ferr++;
            if (RX_OVERRUN) begin
                n_ovr++;
                ovr_edge = edge_cnt;
            end
            if (RX_PARITY_ERR) n_perr++;
        end
    end

    task automatic clear_mon();
        n_vrise = 0; n_vhigh = 0; n_ferr = 0; n_ovr = 0; n_perr = 0;
        vrise_edge = 0; ovr_edge = 0; vrise_data = 8'h00;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the line at the stop value, positioned so a following call starts back-to-back.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        @(negedge CLK);
        SERIAL_RX = 1'b0;
        fall_edge = edge_cnt;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge CLK);
            SERIAL_RX = d[i];
        end
`ifdef UART_RX_PARITY_EN
        repeat (CPB) @(negedge CLK);
        SERIAL_RX = (^d) ^ par_flip;
`endif
        repeat (CPB) @(negedge CLK);
        SERIAL_RX = stop_b;
        repeat (CPB - 1) @(negedge CLK);
        if (par_flip) begin end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[4] = '{8'h55, 1'b0, 0, 8'h00, 1};
        vecs[5] = '{8'h81, 1'b1, 1, 8'h81, 0};

        RST = 1'b1; SERIAL_RX = 1'b1; RX_READY = 1'b1;
        clear_mon();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("reset_valid", RX_VALID, 0);
        check("reset_data", RX_DATA, 0);
        check("reset_ferr", RX_FRAME_ERR, 0);
        check("reset_ovr", RX_OVERRUN, 0);
        check("reset_perr", RX_PARITY_ERR, 0);
        repeat (5) @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            clear_mon();
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            SERIAL_RX = 1'b1;
            repeat (30) @(negedge CLK);
            check($sformatf("vec%0d_vrise", i), n_vrise, vecs[i].exp_valid);
            if (vecs[i].exp_valid != 0) begin
                check($sformatf("vec%0d_data", i), vrise_data, vecs[i].exp_data);
                check($sformatf("vec%0d_latency", i), vrise_edge - fall_edge, LAT);
                check($sformatf("vec%0d_vhigh", i), n_vhigh, 1);
            end
            check($sformatf("vec%0d_ferr", i), n_ferr, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), n_ovr, 0);
            check($sformatf("vec%0d_perr", i), n_perr, 0);
        end

        // glitch rejection
        clear_mon();
        @(negedge CLK);
        SERIAL_RX = 1'b0;
        repeat (4) @(negedge CLK);
        SERIAL_RX = 1'b1;
        repeat (30) @(negedge CLK);
        check("glitch_vrise", n_vrise, 0);
        check("glitch_ferr", n_ferr, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (30) @(negedge CLK);
        check("glitch_next_vrise", n_vrise, 1);
        check("glitch_next_data", vrise_data, 8'h3C);
        check("glitch_next_latency", vrise_edge - fall_edge, LAT);

        // break: stop low then line held low
        clear_mon();
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge CLK);
        check("break_ferr", n_ferr, 1);
        check("break_vrise", n_vrise, 0);
        SERIAL_RX = 1'b1;
        repeat (10) @(negedge CLK);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (30) @(negedge CLK);
        check("break_next_vrise", n_vrise, 1);
        check("break_next_data", vrise_data, 8'h81);
        check("break_ferr_total", n_ferr, 1);

        // overrun and hold
        clear_mon();
        RX_READY = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (30) @(negedge CLK);
        check("ovr_vrise", n_vrise, 1);
        check("ovr_valid_held", RX_VALID, 1);
        check("ovr_data_held", RX_DATA, 8'h11);
        check("ovr_count", n_ovr, 1);
        check("ovr_edge", ovr_edge - fall_edge, LAT);
        check("ovr_ferr", n_ferr, 0);
        @(negedge CLK);
        RX_READY = 1'b1;
        @(negedge CLK);
        check("ovr_accept_clears", RX_VALID, 0);
        check("ovr_data_after_accept", RX_DATA, 8'h11);

        // reset during bit 3 of 0xF0
        repeat (10) @(negedge CLK);
        clear_mon();
        SERIAL_RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            SERIAL_RX = 1'b0;
            repeat (CPB) @(negedge CLK);
        end
        SERIAL_RX = 1'b0;
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        SERIAL_RX = 1'b1;
        check("rst_valid", RX_VALID, 0);
        check("rst_data", RX_DATA, 0);
        check("rst_ferr", RX_FRAME_ERR, 0);
        check("rst_ovr", RX_OVERRUN, 0);
        repeat (200) @(negedge CLK);
        check("rst_no_vrise", n_vrise, 0);
        check("rst_no_ferr", n_ferr, 0);
        check("rst_no_ovr", n_ovr, 0);
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (30) @(negedge CLK);
        check("rst_next_vrise", n_vrise, 1);
        check("rst_next_data", vrise_data, 8'h0F);
        check("rst_next_latency", vrise_edge - fall_edge, LAT);

`ifdef UART_RX_PARITY_EN
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (30) @(negedge CLK);
        check("par_good_vrise", n_vrise, 1);
        check("par_good_data", vrise_data, 8'h07);
        check("par_good_perr", n_perr, 0);
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (30) @(negedge CLK);
        check("par_bad_vrise", n_vrise, 0);
        check("par_bad_perr", n_perr, 1);
        check("par_bad_ferr", n_ferr, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
